// File: rtl/fir_coef_loader_pkg.sv
// Shared definitions for the FIR coefficient loader: state encoding,
// default bank geometry and the coefficient byte width.
// Build option: FIR_COEF_CHECKSUM_EN adds the CHECK state.
package fir_ctrl_pkg;

    localparam int DEF_NUM_FILTERS = 4;
    localparam int DEF_SEL_W       = 4;
    localparam int BYTE_W          = 8;

`ifdef FIR_COEF_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_LSB = 3'd1,
        GET_MSB = 3'd2,
        WRITE   = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5
    } fir_state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_LSB = 3'd1,
        GET_MSB = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd5
    } fir_state_t;
`endif

endpackage

// File: rtl/fir_coef_loader_if.sv
// Byte-stream input and coefficient-RAM write bus of the loader.
// slave: the loader; master: byte source and filter bank side.
interface fir_coef_loader_if #(
    parameter int SEL_W = fir_ctrl_pkg::DEF_SEL_W
);
    import fir_ctrl_pkg::*;

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic [SEL_W-1:0]  coef_select;
    logic              coefficient_wr_en;
    logic [BYTE_W-1:0] coef_wr_lsb_data;
    logic [BYTE_W-1:0] coef_wr_msb_data;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, coef_select, coefficient_wr_en,
               coef_wr_lsb_data, coef_wr_msb_data
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, coef_select, coefficient_wr_en,
               coef_wr_lsb_data, coef_wr_msb_data
    );
endinterface

// File: rtl/fir_coef_loader_checksum.sv
// 8-bit clearable running-sum accumulator for the load checksum.
// Only instantiated when FIR_COEF_CHECKSUM_EN is defined.
module coef_checksum
    import fir_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] add_data,
    output logic [BYTE_W-1:0] sum
);

    // Mod-256 accumulation of every accepted coefficient byte.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_data;
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: assembles 16-bit coefficients from a byte
// stream and writes them into one filter RAM of the bank, deferring
// writes while the audio path has the bank mid-sweep.
// Build option: FIR_COEF_CHECKSUM_EN adds a trailing checksum byte.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for load_start
// GET_LSB | accepting low byte of current coefficient
// GET_MSB | accepting high byte of current coefficient
// WRITE   | waiting for a safe slot, then strobing the write
// CHECK   | accepting checksum byte (checksum build only)
// DONE    | load_done pulse, back to IDLE
module fir_coef_loader
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_FILTERS = DEF_NUM_FILTERS,
    parameter int SEL_W       = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             audio_en,
    input  logic             fir_busy,
    input  logic             wr_addr_zero,
    input  logic [7:0]       taps_per_filter,
    input  logic             load_start,
    input  logic [SEL_W-1:0] load_filter,
    input  logic             load_abort,
    fir_coef_loader_if.slave bus,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_error
);

    fir_state_t        state;
    logic [7:0]        tap_cnt;
    logic [7:0]        taps_lat;
    logic [SEL_W-1:0]  sel_q;
    logic              wr_en_q;
    logic              ready_q;
    logic [BYTE_W-1:0] lsb_q;
    logic [BYTE_W-1:0] msb_q;
    logic              start_bad;
    logic              byte_take;

    assign bus.coef_select       = sel_q;
    assign bus.coefficient_wr_en = wr_en_q;
    assign bus.byte_ready        = ready_q;
    assign bus.coef_wr_lsb_data  = lsb_q;
    assign bus.coef_wr_msb_data  = msb_q;

    assign start_bad = (taps_per_filter == 8'd0) ||
                       (int'(load_filter) >= NUM_FILTERS) ||
                       !wr_addr_zero;
    assign byte_take = bus.byte_valid && ready_q;

`ifdef FIR_COEF_CHECKSUM_EN
    logic [BYTE_W-1:0] cks_sum;
    logic              cks_clear;
    logic              cks_add;

    assign cks_clear = (state == IDLE) && load_start;
    assign cks_add   = byte_take && ((state == GET_LSB) || (state == GET_MSB));

    coef_checksum u_checksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (cks_clear),
        .add_en   (cks_add),
        .add_data (bus.byte_data),
        .sum      (cks_sum)
    );
`endif

    // Load sequencer; all outputs are registered. Abort beats any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tap_cnt    <= '0;
            taps_lat   <= '0;
            sel_q      <= '0;
            wr_en_q    <= 1'b0;
            ready_q    <= 1'b0;
            lsb_q      <= '0;
            msb_q      <= '0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else if ((state != IDLE) && load_abort) begin
            state      <= IDLE;
            wr_en_q    <= 1'b0;
            ready_q    <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b1;
        end else begin
            wr_en_q   <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (start_bad) begin
                            load_error <= 1'b1;
                        end else begin
                            state      <= GET_LSB;
                            sel_q      <= load_filter;
                            tap_cnt    <= '0;
                            taps_lat   <= taps_per_filter;
                            load_error <= 1'b0;
                            load_busy  <= 1'b1;
                            ready_q    <= 1'b1;
                        end
                    end
                end
                GET_LSB: begin
                    if (byte_take) begin
                        lsb_q <= bus.byte_data;
                        state <= GET_MSB;
                    end
                end
                GET_MSB: begin
                    if (byte_take) begin
                        msb_q   <= bus.byte_data;
                        state   <= WRITE;
                        ready_q <= 1'b0;
                    end
                end
                WRITE: begin
                    if (!(audio_en && fir_busy)) begin
                        wr_en_q <= 1'b1;
                        if (tap_cnt == taps_lat - 8'd1) begin
`ifdef FIR_COEF_CHECKSUM_EN
                            state   <= CHECK;
                            ready_q <= 1'b1;
`else
                            state     <= DONE;
                            load_done <= 1'b1;
`endif
                        end else begin
                            tap_cnt <= tap_cnt + 8'd1;
                            state   <= GET_LSB;
                            ready_q <= 1'b1;
                        end
                    end
                end
`ifdef FIR_COEF_CHECKSUM_EN
                CHECK: begin
                    if (byte_take) begin
                        if (bus.byte_data != cks_sum) load_error <= 1'b1;
                        state     <= DONE;
                        load_done <= 1'b1;
                        ready_q   <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    state     <= IDLE;
                    load_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    ready_q   <= 1'b0;
                    load_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 Parameter NUM_FILTERS, default 4: number of coefficient RAMs in the filter bank.
REQ-002 Parameter SEL_W, default 4: width of the filter-select field.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: audio_en  in  1  audio path running; enables write deferral.
REQ-007 Port: fir_busy  in  1  filter bank mid-MAC sweep (bank fir_en).
REQ-008 Port: wr_addr_zero  in  1  bank coefficient write address is 0.
REQ-009 Port: taps_per_filter  in  8  coefficients per filter.
REQ-010 Port: load_start  in  1  one-cycle request to load one filter.
REQ-011 Port: load_filter  in  SEL_W  target filter index, sampled on load_start.
REQ-012 Port: load_abort  in  1  abandon the current load.
REQ-013 Port: byte_valid/byte_data  in  1/8  coefficient byte stream, LSB byte first.
REQ-014 Port: byte_ready  out  1  byte accepted when byte_valid and byte_ready are both high.
REQ-015 Port: coef_select  out  SEL_W  filter RAM select.
REQ-016 Port: coefficient_wr_en  out  1  one-cycle write strobe.
REQ-017 Port: coef_wr_lsb_data/coef_wr_msb_data  out  8/8  coefficient halves.
REQ-018 Port: load_busy  out  1 / load_done  out  1 pulse / load_error  out  1 sticky.

Function
REQ-019 The FSM SHALL use the states IDLE, GET_LSB, GET_MSB, WRITE, CHECK, DONE.
REQ-020 In IDLE, load_start moves to GET_LSB, latching load_filter into coef_select and zeroing tap_cnt, clearing load_error.
REQ-021 On load_start, if taps_per_filter==0, load_filter>=NUM_FILTERS, or wr_addr_zero==0, the block SHALL set load_error, stay in IDLE, and issue no write.
REQ-022 byte_ready SHALL be high only in GET_LSB and GET_MSB; each accepted byte registers into the lsb or msb output, respectively, and advances the state.
REQ-023 In WRITE, while audio_en and fir_busy are both high, the block SHALL hold with no strobe; otherwise it SHALL assert coefficient_wr_en for exactly one cycle with stable data and select.
REQ-024 After a strobe, if tap_cnt==taps_per_filter-1, the FSM SHALL go to CHECK (macro on) or DONE; otherwise tap_cnt increments and the FSM returns to GET_LSB.
REQ-025 DONE SHALL pulse load_done for one cycle, then return to IDLE.
REQ-026 load_busy SHALL be high in every state except IDLE.
REQ-027 load_start outside IDLE SHALL be ignored.
REQ-028 load_abort in any non-IDLE state SHALL return to IDLE next cycle, set load_error, and produce no strobe that cycle; abort takes priority over a pending write.
REQ-029 taps_per_filter SHALL be sampled at load_start; later changes have no effect on the current load.
REQ-030 Maximum write rate SHALL be one coefficient per 3 cycles.

Reset
REQ-031 On reset, the FSM SHALL go to IDLE and tap_cnt, coef_select, the data outputs, coefficient_wr_en, byte_ready, load_busy, load_done and load_error SHALL all go to 0 at the next edge, including mid-load.

Configuration
REQ-032 Macro FIR_COEF_CHECKSUM_EN defined: after the final write, CHECK SHALL accept one extra byte and compare it with the mod-256 sum of all coefficient bytes of the load; on mismatch, load_error is set, and either way DONE follows.
REQ-033 Macro FIR_COEF_CHECKSUM_EN undefined: CHECK and the accumulator are absent, and the final write goes directly to DONE.

Structure
REQ-034 Package fir_ctrl_pkg SHALL hold the FSM state enum, default NUM_FILTERS and SEL_W, and the byte width constant.
REQ-035 Sub-module coef_checksum (8-bit clearable accumulator) SHALL be instantiated only under FIR_COEF_CHECKSUM_EN; all else stays in the top.

Verification
REQ-036 taps=4, filter 2, bytes 01 00 02 00 03 00 04 00 -> four strobes, select=2, data 0x0001..0x0004, load_done once.
REQ-037 audio_en=1, fir_busy=1 for 10 cycles during WRITE -> no strobe until fir_busy falls, then one strobe with data unchanged.
REQ-038 load_filter=5 with NUM_FILTERS=4, or taps=0, or wr_addr_zero=0 -> load_error=1, no strobe, load_busy stays 0.
REQ-039 load_abort after 2 of 4 writes -> IDLE, load_error=1; a following load_start clears the error and completes normally.
REQ-040 Macro on, taps=1, bytes 10 20 then checksum 30 -> load_done, no error; checksum 31 -> load_error=1.
